// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier (datapath and control FSM).
package mult_pkg;

   localparam int MULT_N = 4;

   // Bit-counter width for an n-bit operand; at least one bit so the counter always exists.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [2*MULT_N:0]   acc_t;
   typedef logic [2*MULT_N-1:0] prod_t;

endpackage

// File: rtl/mult_bit_counter.sv
// Saturating bit counter: counts shifts and flags the last multiplier bit.
module mult_bit_counter
   import mult_pkg::*;
#(
   parameter int N  = MULT_N,
   parameter int CW = cntWidth(MULT_N)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          enable_i,
   output logic [CW-1:0] cnt_o,
   output logic          k_o
);

   localparam logic [CW-1:0] LastBit = CW'(N - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over counting; once the last bit is reached the count holds there instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LastBit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register, cleared immediately by the asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign k_o   = (cnt_q == LastBit);

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath driven by the control FSM strobes.
// Optional macro MULT_PRODUCT_HOLD_EN: registers Product on Done and holds it until the next Load.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Load,
   input  logic         Ad,
   input  logic         Sh,
   input  logic         Done,
   input  logic [N-1:0] Multiplier,
   input  logic [N-1:0] Multiplicand,
   output logic         M,
   output logic         K,
   output logic [2*N-1:0] Product,
   output logic         Product_valid
);

   localparam int CW = cntWidth(N);

   logic [2*N:0]  acc_q;
   logic [2*N:0]  acc_d;
   logic [N:0]    sum;
   logic [CW-1:0] cnt;
   logic          cntEnable;

   // Upper half plus multiplicand, kept N+1 bits wide so the carry lands in ACC[2N].
   always_comb begin
      sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, Multiplicand};
   end

   // Accumulator next state: Load beats everything, then fused add+shift, add alone, shift alone, hold.
   always_comb begin
      acc_d = acc_q;
      if (Load) begin
         acc_d = {{(N+1){1'b0}}, Multiplier};
      end else if (Ad && Sh) begin
         acc_d = {1'b0, sum, acc_q[N-1:1]};
      end else if (Ad) begin
         acc_d = {sum, acc_q[N-1:0]};
      end else if (Sh) begin
         acc_d = {1'b0, acc_q[2*N:1]};
      end
   end

   // Accumulator register, discarded immediately on reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign cntEnable = Sh && !Load;

   mult_bit_counter #(
      .N  (N),
      .CW (CW)
   ) u_counter (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .clear_i  (Load),
      .enable_i (cntEnable),
      .cnt_o    (cnt),
      .k_o      (K)
   );

   assign M = acc_q[0];

`ifdef MULT_PRODUCT_HOLD_EN
   logic [2*N-1:0] product_q;
   logic           valid_q;

   // Capture the result on Done and keep it while the next operation reuses the accumulator.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         product_q <= '0;
         valid_q   <= 1'b0;
      end else if (Load) begin
         valid_q   <= 1'b0;
      end else if (Done) begin
         product_q <= acc_q[2*N-1:0];
         valid_q   <= 1'b1;
      end
   end

   assign Product       = product_q;
   assign Product_valid = valid_q;
`else
   // Without the hold register the accumulator is the product, valid only while Done is asserted.
   assign Product       = acc_q[2*N-1:0];
   assign Product_valid = Done;
   logic unusedCnt;
   assign unusedCnt = ^cnt;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath with N=4.
module tb_mult_datapath;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Load, Ad, Sh, Done;
   logic [3:0] Multiplier, Multiplicand;
   logic       M, K;
   logic [7:0] Product;
   logic       Product_valid;

   int compared = 0;
   int mismatched = 0;

   mult_datapath #(.N(4)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Load          (Load),
      .Ad            (Ad),
      .Sh            (Sh),
      .Done          (Done),
      .Multiplier    (Multiplier),
      .Multiplicand  (Multiplicand),
      .M             (M),
      .K             (K),
      .Product       (Product),
      .Product_valid (Product_valid)
   );

   // Free-running clock, period 10.
   always #5 Clk = ~Clk;

   // Advance one rising edge and settle 1 unit past it, where outputs are sampled and inputs changed.
   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // One complete multiplication driven like the control FSM, checking M/K per bit and the result.
   task automatic runMult(input logic [3:0] a, input logic [3:0] b, input bit fused,
                          input logic [7:0] expProd, input string name);
      logic bitVal;
      Multiplier = a; Multiplicand = b; Load = 1'b1; Ad = 1'b0; Sh = 1'b0;
      tick;
      Load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bitVal = a[i];
         compared++;
         if (M !== bitVal) begin
            mismatched++;
            $display("[TB] FAIL %s M bit%0d: got %b expected %b", name, i, M, bitVal);
         end
         compared++;
         if (K !== (i == 3)) begin
            mismatched++;
            $display("[TB] FAIL %s K bit%0d: got %b expected %b", name, i, K, (i == 3));
         end
         if (fused) begin
            Ad = bitVal; Sh = 1'b1;
            tick;
            Ad = 1'b0; Sh = 1'b0;
         end else begin
            if (bitVal) begin
               Ad = 1'b1;
               tick;
               Ad = 1'b0;
            end
            Sh = 1'b1;
            tick;
            Sh = 1'b0;
         end
      end
      compared++;
      if (K !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL %s K after last shift: got %b expected 1", name, K);
      end
      Done = 1'b1;
      tick;
      compared++;
      if (Product !== expProd || Product_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL %s product: got %0d valid %b expected %0d valid 1",
                  name, Product, Product_valid, expProd);
      end
      Done = 1'b0;
   endtask

   task automatic test_reset;
      Reset_n = 1'b0; Load = 0; Ad = 0; Sh = 0; Done = 0; Multiplier = 0; Multiplicand = 0;
      #12;
      compared++;
      if (M !== 1'b0 || K !== 1'b0 || Product !== 8'd0 || Product_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset outputs: got M=%b K=%b P=%0d V=%b expected all 0",
                  M, K, Product, Product_valid);
      end
      Reset_n = 1'b1;
      tick;
      Done = 1'b1;
      tick;
      compared++;
      if (Product !== 8'd0 || Product_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL done_no_load: got P=%0d V=%b expected P=0 V=1", Product, Product_valid);
      end
      Done = 1'b0;
      tick;
   endtask

   task automatic test_basic;
      runMult(4'd13, 4'd11, 1'b0, 8'h8F, "13x11");
      runMult(4'd0, 4'd9, 1'b0, 8'h00, "0x9");
      runMult(4'd9, 4'd0, 1'b0, 8'h00, "9x0");
   endtask

   // 15x15 by hand so the carry into ACC[8] can be seen after the second add.
   task automatic test_carry;
      runMult(4'd15, 4'd15, 1'b0, 8'hE1, "15x15");
      Multiplier = 4'd15; Multiplicand = 4'd15; Load = 1'b1;
      tick;
      Load = 1'b0; Ad = 1'b1;
      tick;
      Ad = 1'b0; Sh = 1'b1;
      tick;
      Sh = 1'b0; Ad = 1'b1;
      tick;
      Ad = 1'b0;
      compared++;
      if (dut.acc_q !== 9'h16F) begin
         mismatched++;
         $display("[TB] FAIL carry acc: got %h expected 16f", dut.acc_q);
      end
      Sh = 1'b1;
      tick;
      Sh = 1'b0;
      compared++;
      if (dut.acc_q !== 9'h0B7) begin
         mismatched++;
         $display("[TB] FAIL carry shift: got %h expected 0b7", dut.acc_q);
      end
   endtask

   task automatic test_fused;
      runMult(4'd13, 4'd11, 1'b1, 8'h8F, "fused13x11");
   endtask

   task automatic test_reset_mid;
      Multiplier = 4'd13; Multiplicand = 4'd11; Load = 1'b1;
      tick;
      Load = 1'b0; Ad = 1'b1;
      tick;
      Ad = 1'b0; Sh = 1'b1;
      tick;
      Sh = 1'b0; Ad = 1'b1;
      #3;
      Reset_n = 1'b0;
      #1;
      compared++;
      if (dut.acc_q !== 9'd0 || dut.u_counter.cnt_q !== 2'd0 || M !== 1'b0 || K !== 1'b0 ||
          Product !== 8'd0 || Product_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid: got acc=%h cnt=%0d M=%b K=%b P=%0d V=%b expected all 0",
                  dut.acc_q, dut.u_counter.cnt_q, M, K, Product, Product_valid);
      end
      Ad = 1'b0;
      #2;
      Reset_n = 1'b1;
      tick;
      runMult(4'd6, 4'd7, 1'b0, 8'd42, "6x7");
   endtask

   task automatic test_load_priority;
      runMult(4'd13, 4'd11, 1'b0, 8'h8F, "pre_load");
`ifdef MULT_PRODUCT_HOLD_EN
      Sh = 1'b1;
      tick;
      Sh = 1'b0;
      compared++;
      if (Product !== 8'h8F || Product_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL hold: got P=%0d V=%b expected P=143 V=1", Product, Product_valid);
      end
`endif
      Multiplier = 4'd5; Load = 1'b1; Ad = 1'b1; Sh = 1'b1;
      tick;
      Load = 1'b0; Ad = 1'b0; Sh = 1'b0;
      compared++;
      if (dut.acc_q !== 9'd5 || dut.u_counter.cnt_q !== 2'd0 || M !== 1'b1 || K !== 1'b0 ||
          Product_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL load_priority: got acc=%h cnt=%0d M=%b K=%b V=%b expected 005 0 1 0 0",
                  dut.acc_q, dut.u_counter.cnt_q, M, K, Product_valid);
      end
   endtask

   // Scenario sequence followed by the summary.
   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_fused;
      test_reset_mid;
      test_load_priority;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
